calendar_date_ctrl: RTL and testbench
=====================================

Name: calendar_date_ctrl

Overview:
Calendar date register and sequencer for the clock's date display.
- Holds year (BCD offset from 2000, range 000..199), month and day.
- Advances the date on the midnight carry from the time-of-day counter.
- Provides a button-driven set mode (year → month → day).
- Drives two leap_year instances: one on the current year, one on the candidate next year. Together they determine days-in-month and clamp the day field.

Parameters:
- YEAR_MAX_BCD, 12'h199, last valid year offset; the year wraps to 12'h000 after it.
- RST_YEAR_BCD, 12'h000, year value at reset (year 2000).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- day_tick  input  1  one-cycle pulse; midnight carry from time-of-day counter
- btn_mode  input  1  one-cycle pulse, debounced upstream; cycles the set mode
- btn_inc  input  1  one-cycle pulse, debounced upstream; increments the selected field
- year_bcd  output  12  year offset, 3 BCD digits (hunds, tens, ones)
- month_bcd  output  8  month, 2 BCD digits, 01..12
- day_bcd  output  8  day, 2 BCD digits, 01..31
- is_leap  output  1  leap flag for current year_bcd; combinational from the year register
- set_sel  output  2  mode indicator: 00 RUN, 01 SET_YEAR, 10 SET_MONTH, 11 SET_DAY

Behaviour:
- Reset (rst_n low, asynchronous):
  - year_bcd = RST_YEAR_BCD, month_bcd = 8'h01, day_bcd = 8'h01.
  - State RUN, set_sel = 00.
  - is_leap follows the year (1 for year 000).
- Registers: all date registers update on the rising clk edge; outputs change one cycle after the triggering pulse.
- Days-in-month (dim), from a given month and leap flag:
  - 04, 06, 09, 11 → 30.
  - 02 → 29 if leap, else 28.
  - All other months → 31.
- FSM transitions on btn_mode: RUN → SET_YEAR → SET_MONTH → SET_DAY → RUN.
- RUN with day_tick:
  - day < dim → day + 1.
  - day == dim → day = 01 and month + 1.
  - month == 12 at that rollover → month = 01 and year + 1.
  - year == YEAR_MAX_BCD at that rollover → year = 000.
- BCD arithmetic: all increments are digit-wise BCD (ones 9 → 0 with carry). Binary increment is forbidden; 8'h09 + 1 = 8'h10.
- SET states:
  - day_tick is ignored and dropped, not queued; time-of-day keeps running, but that day is lost.
  - btn_inc increments only the selected field, with wrap:
    - year: YEAR_MAX_BCD → 000.
    - month: 12 → 01.
    - day: dim(current month, is_leap) → 01.
  - No carry into other fields.
- Day clamp: whenever year or month changes in a SET state, next day = min(day, dim(next month, leap(next year))).
  - The clamp happens in the same cycle as the change.
  - leap(next year) comes from the second leap_year instance fed with the next-year value.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: mode transition occurs, inc is dropped.
  - day_tick and btn_mode in RUN in the same cycle: the tick is applied, then the state becomes SET_YEAR.
- Reset mid-set: returns to RUN with reset date; partial edits are discarded.
- Invariant: the registers never hold an invalid BCD digit or an invalid date (e.g. 02-30, 04-31, day 00, month 00/13). Assertions must check this every cycle.

Test Plan:
- Reset: assert rst_n = 0 asynchronously mid-cycle → year 000, month 01, day 01, set_sel 00, is_leap 1 immediately.
- Leap Feb: set date to 028-02-28, pulse day_tick → 02-29; pulse again → 03-01. With 027-02-28, one tick → 03-01.
- Century: 100-02-28 (2100) → is_leap 0; tick → 100-03-01. 000-02-28 → tick → 02-29.
- Wrap and BCD carry:
  - 199-12-31 + tick → 000-01-01.
  - 009-01-09 + tick → day 10.
  - 019-12-31 + tick → year 020.
- Set clamp:
  - 000-01-31 in SET_MONTH, btn_inc → 000-02-29.
  - Then SET_YEAR × 1 inc → 001-02-28.
  - SET_DAY inc at 28 → 01.
- Contention:
  - day_tick during SET_DAY → date unchanged.
  - btn_mode + btn_inc same cycle in SET_YEAR → state SET_MONTH, year unchanged.
  - Reset asserted in SET_MONTH after edits → reset date, RUN.

Source files
------------

// File: rtl/calendar_date_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : leap_year / calendar_date_ctrl
// Description : Calendar date register (year offset from 2000, month, day) with
//               midnight advance, button-driven set mode and day clamping.
// Revision    : 1.0 - initial release
// ============================================================================

// Leap flag for a 3-digit BCD year offset from 2000 (years 2000..2199).
module leap_year (
  input  logic [11:0] year_bcd_i,
  output logic        is_leap_o
);

  logic [3:0] w_hund;
  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic       w_div4;
  logic       w_century;
  logic       w_cent_leap;

  assign w_hund = year_bcd_i[11:8];
  assign w_tens = year_bcd_i[7:4];
  assign w_ones = year_bcd_i[3:0];

  // Last two decimal digits divisible by 4: even tens needs ones 0/4/8, odd tens needs 2/6.
  assign w_div4 = w_tens[0] ? ((w_ones == 4'd2) || (w_ones == 4'd6))
                            : ((w_ones == 4'd0) || (w_ones == 4'd4) || (w_ones == 4'd8));

  // Century years are leap only when (20 + hundreds) is divisible by 4.
  assign w_century   = (w_tens == 4'd0) && (w_ones == 4'd0);
  assign w_cent_leap = (w_hund == 4'd0) || (w_hund == 4'd4) || (w_hund == 4'd8);

  assign is_leap_o = w_century ? w_cent_leap : w_div4;

endmodule

module calendar_date_ctrl #(
  parameter logic [11:0] YEAR_MAX_BCD = 12'h199,
  parameter logic [11:0] RST_YEAR_BCD = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        day_tick,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [11:0] year_bcd,
  output logic [7:0]  month_bcd,
  output logic [7:0]  day_bcd,
  output logic        is_leap,
  output logic [1:0]  set_sel
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_SET_YEAR  = 2'b01,
    ST_SET_MONTH = 2'b10,
    ST_SET_DAY   = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] year_q,  year_d;
  logic [7:0]  month_q, month_d;
  logic [7:0]  day_q,   day_d;

  logic [7:0]  w_day_base;
  logic [11:0] w_year_inc;
  logic [7:0]  w_month_inc;
  logic [7:0]  w_day_inc;
  logic [7:0]  w_dim_cur;
  logic [7:0]  w_dim_next;
  logic        w_leap_next;

  // Two-digit BCD increment, no range wrap.
  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Three-digit BCD increment, no range wrap.
  function automatic logic [11:0] bcd_inc3(input logic [11:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd9) return {v[11:8] + 4'd1, 8'h00};
      else                return {v[11:8], v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[11:4], v[3:0] + 4'd1};
    end
  endfunction

  // Days in month, returned as BCD.
  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic leap);
    case (m)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return leap ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction

  // Current year drives the status flag and the current month length.
  leap_year u_leap_cur (
    .year_bcd_i (year_q),
    .is_leap_o  (is_leap)
  );

  // Candidate next year drives the clamp limit for set-mode edits.
  leap_year u_leap_next (
    .year_bcd_i (year_d),
    .is_leap_o  (w_leap_next)
  );

  assign w_dim_cur   = days_in_month(month_q, is_leap);
  assign w_year_inc  = (year_q == YEAR_MAX_BCD) ? 12'h000 : bcd_inc3(year_q);
  assign w_month_inc = (month_q == 8'h12) ? 8'h01 : bcd_inc2(month_q);
  assign w_day_inc   = (day_q == w_dim_cur) ? 8'h01 : bcd_inc2(day_q);

  // State and date registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      year_q  <= RST_YEAR_BCD;
      month_q <= 8'h01;
      day_q   <= 8'h01;
    end else begin
      state_q <= state_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
    end
  end

  // Mode sequencing, midnight advance and set-mode field increments.
  always_comb begin
    state_d    = state_q;
    year_d     = year_q;
    month_d    = month_q;
    w_day_base = day_q;
    case (state_q)
      ST_RUN: begin
        // The tick is applied even when btn_mode arrives in the same cycle.
        if (day_tick) begin
          if (day_q == w_dim_cur) begin
            w_day_base = 8'h01;
            month_d    = w_month_inc;
            if (month_q == 8'h12) year_d = w_year_inc;
          end else begin
            w_day_base = bcd_inc2(day_q);
          end
        end
        if (btn_mode) state_d = ST_SET_YEAR;
      end
      ST_SET_YEAR: begin
        if (btn_mode)     state_d = ST_SET_MONTH;
        else if (btn_inc) year_d  = w_year_inc;
      end
      ST_SET_MONTH: begin
        if (btn_mode)     state_d = ST_SET_DAY;
        else if (btn_inc) month_d = w_month_inc;
      end
      ST_SET_DAY: begin
        if (btn_mode)     state_d    = ST_RUN;
        else if (btn_inc) w_day_base = w_day_inc;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Clamp the day when a set-mode edit shortens the month.
  always_comb begin
    w_dim_next = days_in_month(month_d, w_leap_next);
    day_d      = w_day_base;
    if ((state_q != ST_RUN) && ((year_d != year_q) || (month_d != month_q)) &&
        (w_day_base > w_dim_next)) begin
      day_d = w_dim_next;
    end
  end

  assign year_bcd  = year_q;
  assign month_bcd = month_q;
  assign day_bcd   = day_q;
  assign set_sel   = state_q;

`ifndef SYNTHESIS
  logic w_digits_ok;
  logic w_date_ok;

  assign w_digits_ok = (year_q[11:8] <= 4'd9) && (year_q[7:4] <= 4'd9) &&
                       (year_q[3:0] <= 4'd9) && (month_q[7:4] <= 4'd9) &&
                       (month_q[3:0] <= 4'd9) && (day_q[7:4] <= 4'd9) &&
                       (day_q[3:0] <= 4'd9);
  assign w_date_ok   = (year_q <= YEAR_MAX_BCD) &&
                       (month_q >= 8'h01) && (month_q <= 8'h12) &&
                       (day_q >= 8'h01) && (day_q <= w_dim_cur);

  // Registered date must always be a legal BCD calendar date.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (w_digits_ok);
      assert (w_date_ok);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_calendar_date_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_calendar_date_ctrl
// Description : Directed self-checking bench for calendar_date_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calendar_date_ctrl;

  logic        clk;
  logic        rst_n;
  logic        day_tick;
  logic        btn_mode;
  logic        btn_inc;
  logic [11:0] year_bcd;
  logic [7:0]  month_bcd;
  logic [7:0]  day_bcd;
  logic        is_leap;
  logic [1:0]  set_sel;

  int checks = 0;
  int errors = 0;

  calendar_date_ctrl #(
    .YEAR_MAX_BCD (12'h199),
    .RST_YEAR_BCD (12'h000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .day_tick  (day_tick),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .year_bcd  (year_bcd),
    .month_bcd (month_bcd),
    .day_bcd   (day_bcd),
    .is_leap   (is_leap),
    .set_sel   (set_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {year, month, day, set_sel, is_leap}
  function automatic logic [30:0] obs();
    return {year_bcd, month_bcd, day_bcd, set_sel, is_leap};
  endfunction

  // One-cycle pulse on the chosen inputs; outputs are settled on return.
  task automatic pulse(input bit m, input bit i, input bit t);
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    day_tick = t;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    day_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset, then walk the set modes to load y-m-d (decimal) and return to RUN.
  task automatic set_date(input int y, input int m, input int d);
    do_reset();
    pulse(1, 0, 0);
    for (int k = 0; k < y; k++) pulse(0, 1, 0);
    pulse(1, 0, 0);
    for (int k = 1; k < m; k++) pulse(0, 1, 0);
    pulse(1, 0, 0);
    for (int k = 1; k < d; k++) pulse(0, 1, 0);
    pulse(1, 0, 0);
  endtask

  task automatic test_reset();
    logic [30:0] exp;
    rst_n = 1'b0; day_tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp = {12'h000, 8'h01, 8'h01, 2'b00, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL reset_init: got %h exp %h", obs(), exp); end
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    exp = {12'h000, 8'h01, 8'h02, 2'b01, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL tick_then_mode: got %h exp %h", obs(), exp); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    exp = {12'h000, 8'h01, 8'h01, 2'b00, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL reset_async: got %h exp %h", obs(), exp); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_leap_feb();
    logic [30:0] exp;
    set_date(28, 2, 28);
    exp = {12'h028, 8'h02, 8'h28, 2'b00, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL load_028_02_28: got %h exp %h", obs(), exp); end
    pulse(0, 0, 1);
    exp = {12'h028, 8'h02, 8'h29, 2'b00, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL leap_feb29: got %h exp %h", obs(), exp); end
    pulse(0, 0, 1);
    exp = {12'h028, 8'h03, 8'h01, 2'b00, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL leap_mar01: got %h exp %h", obs(), exp); end
    set_date(27, 2, 28);
    pulse(0, 0, 1);
    exp = {12'h027, 8'h03, 8'h01, 2'b00, 1'b0};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL nonleap_mar01: got %h exp %h", obs(), exp); end
  endtask

  task automatic test_century();
    logic [30:0] exp;
    set_date(100, 2, 28);
    checks++;
    if (is_leap !== 1'b0) begin errors++; $display("FAIL leap_2100: got %b exp 0", is_leap); end
    pulse(0, 0, 1);
    exp = {12'h100, 8'h03, 8'h01, 2'b00, 1'b0};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL century_2100_tick: got %h exp %h", obs(), exp); end
    set_date(0, 2, 28);
    pulse(0, 0, 1);
    exp = {12'h000, 8'h02, 8'h29, 2'b00, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL century_2000_tick: got %h exp %h", obs(), exp); end
  endtask

  task automatic test_wrap();
    logic [30:0] exp;
    set_date(199, 12, 31);
    pulse(0, 0, 1);
    exp = {12'h000, 8'h01, 8'h01, 2'b00, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL year_wrap: got %h exp %h", obs(), exp); end
    set_date(9, 1, 9);
    pulse(0, 0, 1);
    exp = {12'h009, 8'h01, 8'h10, 2'b00, 1'b0};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL day_bcd_carry: got %h exp %h", obs(), exp); end
    set_date(19, 12, 31);
    pulse(0, 0, 1);
    exp = {12'h020, 8'h01, 8'h01, 2'b00, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL year_bcd_carry: got %h exp %h", obs(), exp); end
    set_date(5, 4, 30);
    pulse(0, 0, 1);
    exp = {12'h005, 8'h05, 8'h01, 2'b00, 1'b0};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL apr30_rollover: got %h exp %h", obs(), exp); end
  endtask

  task automatic test_set_clamp();
    logic [30:0] exp;
    do_reset();
    repeat (3) pulse(1, 0, 0);
    for (int k = 0; k < 30; k++) pulse(0, 1, 0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    exp = {12'h000, 8'h01, 8'h31, 2'b10, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL load_jan31: got %h exp %h", obs(), exp); end
    pulse(0, 1, 0);
    exp = {12'h000, 8'h02, 8'h29, 2'b10, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL clamp_month: got %h exp %h", obs(), exp); end
    repeat (3) pulse(1, 0, 0);
    pulse(0, 1, 0);
    exp = {12'h001, 8'h02, 8'h28, 2'b01, 1'b0};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL clamp_year: got %h exp %h", obs(), exp); end
    repeat (2) pulse(1, 0, 0);
    pulse(0, 1, 0);
    exp = {12'h001, 8'h02, 8'h01, 2'b11, 1'b0};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL set_day_wrap: got %h exp %h", obs(), exp); end
  endtask

  task automatic test_contention();
    logic [30:0] exp;
    pulse(0, 0, 1);
    exp = {12'h001, 8'h02, 8'h01, 2'b11, 1'b0};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL tick_in_set_day: got %h exp %h", obs(), exp); end
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(1, 1, 0);
    exp = {12'h001, 8'h02, 8'h01, 2'b10, 1'b0};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL mode_and_inc: got %h exp %h", obs(), exp); end
    pulse(0, 1, 0);
    exp = {12'h001, 8'h03, 8'h01, 2'b10, 1'b0};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL month_edit: got %h exp %h", obs(), exp); end
    do_reset();
    exp = {12'h000, 8'h01, 8'h01, 2'b00, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL reset_mid_set: got %h exp %h", obs(), exp); end
  endtask

  task automatic test_back_to_back();
    logic [30:0] exp;
    set_date(4, 6, 30);
    pulse(1, 0, 1);
    exp = {12'h004, 8'h07, 8'h01, 2'b01, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL tick_with_mode: got %h exp %h", obs(), exp); end
  endtask

  initial begin
    test_reset();
    test_leap_feb();
    test_century();
    test_wrap();
    test_set_clamp();
    test_contention();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
